// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write/read bus of regfile_mp (two write ports, two registered read ports)
// Ports: we0/waddr0/wdata0 and we1/waddr1/wdata1 write; raddr0/raddr1 in, rdata0/rdata1 out
interface regfile_mp_if #(
  parameter int WIDTH = 16,
  parameter int AW = 3
);
  logic             we0;
  logic [AW-1:0]    waddr0;
  logic [WIDTH-1:0] wdata0;
  logic             we1;
  logic [AW-1:0]    waddr1;
  logic [WIDTH-1:0] wdata1;
  logic [AW-1:0]    raddr0;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr0, raddr1,
    input  rdata0, rdata1
  );
  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr0, raddr1,
    output rdata0, rdata1
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2-write/2-read register file, write-first registered reads, optional zero register
// Ports: clk, reset (async, active-high), bus (regfile_mp_if.slave: write ports 0/1, read ports 0/1)
module regfile_mp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter bit ZERO_REG = 1'b0
) (
  input logic        clk,
  input logic        reset,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd0, r_rd1, w_rd0, w_rd1;
  logic             w_we0, w_we1;
  // writes to the hard-wired zero register are dropped entirely, so they never bypass either
  assign w_we0 = bus.we0 && !(ZERO_REG && bus.waddr0 == '0);
  assign w_we1 = bus.we1 && !(ZERO_REG && bus.waddr1 == '0);
  // write-first: port 1 write beats port 0 write beats stored value
  always_comb begin
    w_rd0 = (ZERO_REG && bus.raddr0 == '0) ? '0 :
            (w_we1 && bus.waddr1 == bus.raddr0) ? bus.wdata1 :
            (w_we0 && bus.waddr0 == bus.raddr0) ? bus.wdata0 : r_mem[bus.raddr0];
    w_rd1 = (ZERO_REG && bus.raddr1 == '0) ? '0 :
            (w_we1 && bus.waddr1 == bus.raddr1) ? bus.wdata1 :
            (w_we0 && bus.waddr0 == bus.raddr1) ? bus.wdata0 : r_mem[bus.raddr1];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_we1 && bus.waddr1 == AW'(i)) r_mem[i] <= bus.wdata1;
        else if (w_we0 && bus.waddr0 == AW'(i)) r_mem[i] <= bus.wdata0;
      r_rd0 <= w_rd0;
      r_rd1 <= w_rd1;
    end
  assign bus.rdata0 = r_rd0;
  assign bus.rdata1 = r_rd1;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven bench for regfile_mp (16x8, 16x8 zero-reg, 32x32 builds)
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile_mp_if #(.WIDTH(16), .AW(3)) b8();
  regfile_mp_if #(.WIDTH(16), .AW(3)) bz();
  regfile_mp_if #(.WIDTH(32), .AW(5)) b32();
  regfile_mp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) u8 (.clk(clk), .reset(reset), .bus(b8));
  regfile_mp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1)) uz (.clk(clk), .reset(reset), .bus(bz));
  regfile_mp #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0)) u32 (.clk(clk), .reset(reset), .bus(b32));
  typedef struct {
    logic        we0;
    logic [2:0]  wa0;
    logic [15:0] wd0;
    logic        we1;
    logic [2:0]  wa1;
    logic [15:0] wd1;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;
  vec_t vecs[64];
  int nv = 0;
  task automatic add(input logic we0, input logic [2:0] wa0, input logic [15:0] wd0,
                     input logic we1, input logic [2:0] wa1, input logic [15:0] wd1,
                     input logic [2:0] ra0, input logic [2:0] ra1,
                     input logic [15:0] e0, input logic [15:0] e1);
    vecs[nv] = '{we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, e0, e1};
    nv++;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drv8(input logic we0, input logic [2:0] wa0, input logic [15:0] wd0,
                      input logic we1, input logic [2:0] wa1, input logic [15:0] wd1,
                      input logic [2:0] ra0, input logic [2:0] ra1);
    b8.we0 = we0; b8.waddr0 = wa0; b8.wdata0 = wd0;
    b8.we1 = we1; b8.waddr1 = wa1; b8.wdata1 = wd1;
    b8.raddr0 = ra0; b8.raddr1 = ra1;
  endtask
  task automatic drvz(input logic we0, input logic [2:0] wa0, input logic [15:0] wd0,
                      input logic we1, input logic [2:0] wa1, input logic [15:0] wd1,
                      input logic [2:0] ra0, input logic [2:0] ra1);
    bz.we0 = we0; bz.waddr0 = wa0; bz.wdata0 = wd0;
    bz.we1 = we1; bz.waddr1 = wa1; bz.wdata1 = wd1;
    bz.raddr0 = ra0; bz.raddr1 = ra1;
  endtask
  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 16'hC0DE + 16'(i)};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drv8(0, 0, 0, 0, 0, 0, 0, 0);
    drvz(0, 0, 0, 0, 0, 0, 0, 0);
    b32.we0 = 0; b32.waddr0 = 0; b32.wdata0 = 0;
    b32.we1 = 0; b32.waddr1 = 0; b32.wdata1 = 0;
    b32.raddr0 = 0; b32.raddr1 = 0;
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, 3'(i), 3'(i), 16'h0, 16'h0);
    for (int i = 0; i < 8; i++)
      add(i % 2 == 0, 3'(i), 16'(i + 1), i % 2 == 1, 3'(i), 16'(i + 1), 3'(i), 3'd0, 16'(i + 1), 16'h1);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, 3'(i), 3'(7 - i), 16'(i + 1), 16'(8 - i));
    add(1, 2, 16'h00AA, 1, 5, 16'h0055, 2, 5, 16'h00AA, 16'h0055);
    add(0, 0, 0, 0, 0, 0, 5, 2, 16'h0055, 16'h00AA);
    add(1, 4, 16'h1111, 1, 4, 16'h2222, 4, 4, 16'h2222, 16'h2222);
    add(0, 0, 0, 0, 0, 0, 4, 3, 16'h2222, 16'h0004);
    add(1, 6, 16'h0006, 0, 0, 0, 6, 6, 16'h0006, 16'h0006);
    add(1, 6, 16'hBEEF, 0, 0, 0, 6, 6, 16'hBEEF, 16'hBEEF);
    add(0, 0, 0, 0, 0, 0, 6, 4, 16'hBEEF, 16'h2222);
    add(1, 1, 16'h0101, 1, 7, 16'h0707, 7, 1, 16'h0707, 16'h0101);
    add(0, 0, 0, 0, 0, 0, 1, 7, 16'h0101, 16'h0707);
    add(1, 0, 16'hFFFF, 1, 0, 16'hFFFF, 0, 0, 16'hFFFF, 16'hFFFF);
    add(0, 0, 0, 0, 0, 0, 0, 2, 16'hFFFF, 16'h00AA);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset rd0", 32'(b8.rdata0), 32'h0);
    check("reset rd1", 32'(b8.rdata1), 32'h0);
    drv8(1, 3, 16'h1234, 0, 0, 0, 3, 3);
    step();
    check("pre-reset rd0", 32'(b8.rdata0), 32'h1234);
    check("pre-reset rd1", 32'(b8.rdata1), 32'h1234);
    drv8(0, 0, 0, 0, 0, 0, 3, 3);
    #3 reset = 1'b1;
    #1;
    check("async reset rd0", 32'(b8.rdata0), 32'h0);
    check("async reset rd1", 32'(b8.rdata1), 32'h0);
    drv8(1, 3, 16'h5555, 0, 0, 0, 3, 3);
    step();
    check("reset held rd0", 32'(b8.rdata0), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < nv; k++) begin
      drv8(vecs[k].we0, vecs[k].wa0, vecs[k].wd0, vecs[k].we1, vecs[k].wa1, vecs[k].wd1,
           vecs[k].ra0, vecs[k].ra1);
      step();
      check($sformatf("vec%0d rd0", k), 32'(b8.rdata0), 32'(vecs[k].e0));
      check($sformatf("vec%0d rd1", k), 32'(b8.rdata1), 32'(vecs[k].e1));
    end
    drv8(0, 0, 0, 0, 0, 0, 0, 0);
    drvz(1, 0, 16'hFFFF, 1, 0, 16'hFFFF, 0, 0);
    step();
    check("zreg wr0 rd0", 32'(bz.rdata0), 32'h0);
    check("zreg wr0 rd1", 32'(bz.rdata1), 32'h0);
    drvz(1, 1, 16'h1234, 1, 0, 16'hFFFF, 0, 1);
    step();
    check("zreg drop rd0", 32'(bz.rdata0), 32'h0);
    check("zreg p0 rd1", 32'(bz.rdata1), 32'h1234);
    drvz(1, 0, 16'hAAAA, 1, 2, 16'h5555, 2, 0);
    step();
    check("zreg p1 rd0", 32'(bz.rdata0), 32'h5555);
    check("zreg p1 rd1", 32'(bz.rdata1), 32'h0);
    drvz(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    check("zreg hold rd0", 32'(bz.rdata0), 32'h0);
    check("zreg hold rd1", 32'(bz.rdata1), 32'h1234);
    drvz(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      b32.we0 = 1; b32.waddr0 = 5'(i); b32.wdata0 = pat(i);
      b32.we1 = 1; b32.waddr1 = 5'(i + 16); b32.wdata1 = pat(i + 16);
      b32.raddr0 = 5'(i); b32.raddr1 = 5'(i + 16);
      step();
      check($sformatf("w32 fill%0d rd0", i), b32.rdata0, pat(i));
      check($sformatf("w32 fill%0d rd1", i), b32.rdata1, pat(i + 16));
    end
    b32.we0 = 0; b32.we1 = 0;
    for (int i = 0; i < 32; i++) begin
      b32.raddr0 = 5'(i); b32.raddr1 = 5'(31 - i);
      step();
      check($sformatf("w32 read%0d rd0", i), b32.rdata0, pat(i));
      check($sformatf("w32 read%0d rd1", i), b32.rdata1, pat(31 - i));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the successor to the 8×16 single-write-port register file. It provides two independent write ports and two read ports with a registered, write-first read path. An optional hard-wired zero register is included. It sits in the datapath between decode (addresses) and the ALU/writeback stages (operands and results).

## Interface
Parameters:
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 8, number of registers (≥2, power of two)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 0, when 1 register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and both read outputs
- we0  in  1  write enable, port 0
- waddr0  in  AW  write address, port 0
- wdata0  in  WIDTH  write data, port 0
- we1  in  1  write enable, port 1
- waddr1  in  AW  write address, port 1
- wdata1  in  WIDTH  write data, port 1
- raddr0  in  AW  read address, port 0
- raddr1  in  AW  read address, port 1
- rdata0  out  WIDTH  registered read data, port 0
- rdata1  out  WIDTH  registered read data, port 1

## Operation
- Storage: DEPTH words of WIDTH bits, all 0 after reset.
- Write: on a rising edge with weN=1, reg[waddrN] ← wdataN.
- Write collision: we0=we1=1 and waddr0==waddr1 → port 1 wins; port 0 data is discarded for that edge.
- Different addresses with both enables → both written the same edge.
- Read: on every rising edge, rdataN ← value of reg[raddrN] as it stands after that edge's writes (write-first).
- Bypass priority for rdataN: port 1 write match, then port 0 write match, then the stored value.
- ZERO_REG=1:
  - writes to address 0 from either port are dropped (no storage update, no bypass);
  - reads of address 0 return 0.
- ZERO_REG=0: address 0 behaves like any other register.
- Read ports are fully independent; both may address the same register.
- No illegal addresses exist (DEPTH is a power of two).

## Timing
- Read latency: 1 cycle. raddr sampled at edge k; rdata valid after edge k, held until edge k+1.
- Write-to-read: a write at edge k to address A, with raddr=A at edge k, gives the new data on rdata after edge k (0-cycle RAW hazard).
- Reset: asserted asynchronously → all registers = 0 and rdata0 = rdata1 = 0 immediately, without waiting for clk.
- Reset held: writes ignored; rdata held at 0.
- Reset deasserted: the first write and read take effect on the first rising edge with reset=0.
- Reset mid-operation: any write in that cycle is lost; no partial state survives.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert reset with registers holding data (e.g. reg3=16'h1234) → rdata0/rdata1 go to 0 before the next edge; after release, reading every address returns 0.
- Fill and read back: write reg[i]=i+1 for i=0..7, alternating port 0 and port 1. Then read raddr0=i, raddr1=7−i each cycle → rdata0=i+1 and rdata1=8−i, each one cycle after its address.
- Dual write: we0 (addr 2, 16'h00AA) and we1 (addr 5, 16'h0055) on the same edge → reads give reg2=16'h00AA, reg5=16'h0055.
- Collision: we0 (addr 4, 16'h1111) and we1 (addr 4, 16'h2222) on the same edge, with raddr0=4 → rdata0=16'h2222 after that edge and on later reads.
- Write-first bypass: reg6=16'h0006; write 16'hBEEF to addr 6 with raddr1=6 on the same edge → rdata1=16'hBEEF after that edge, not 16'h0006.
- ZERO_REG=1 build: write 16'hFFFF to addr 0 on both ports while raddr0=0 → rdata0 stays 0. With ZERO_REG=0, the same stimulus gives rdata0=16'hFFFF.
- Parameter sweep: WIDTH=32, DEPTH=32 → repeat the fill/readback with 32-bit patterns across all 32 addresses, with no aliasing between addresses.
